// File: rtl/dpram_access_arbiter.sv
// dpram_access_arbiter: shares a simple dual-port RAM between two masters,
// with independent round-robin write and read arbiters and write-first forwarding.
module dpram_access_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_doutb
);
    logic                  wr_last_q, rd_last_q;
    logic                  rtag_v_q, rtag_idx_q;
    logic                  fwd_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  wc0, wc1, rc0, rc1;
    logic                  wg0, wg1, rg0, rg1;
    logic                  rd_any, collide;

    // last=1 means master 1 was served last, so master 0 wins the next tie
    always_comb begin
        wc0     = m0_req & m0_we & ~rst;
        wc1     = m1_req & m1_we & ~rst;
        rc0     = m0_req & ~m0_we & ~rst;
        rc1     = m1_req & ~m1_we & ~rst;
        wg0     = wc0 & (~wc1 | wr_last_q);
        wg1     = wc1 & (~wc0 | ~wr_last_q);
        rg0     = rc0 & (~rc1 | rd_last_q);
        rg1     = rc1 & (~rc0 | ~rd_last_q);
        rd_any  = rg0 | rg1;
        ram_wea   = wg0 | wg1;
        ram_addra = wg1 ? m1_addr : m0_addr;
        ram_dina  = wg1 ? m1_wdata : m0_wdata;
        ram_addrb = rg1 ? m1_addr : m0_addr;
        collide   = ram_wea & rd_any & (ram_addra == ram_addrb);
        m0_gnt  = wg0 | rg0;
        m1_gnt  = wg1 | rg1;
        rdata_d = rtag_v_q ? (fwd_q ? fwd_data_q : ram_doutb) : rdata_q;
    end

    assign m0_rvalid = rtag_v_q & ~rtag_idx_q;
    assign m1_rvalid = rtag_v_q & rtag_idx_q;
    assign m0_rdata  = rdata_d;
    assign m1_rdata  = rdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_last_q  <= 1'b1;
            rd_last_q  <= 1'b1;
            rtag_v_q   <= 1'b0;
            rtag_idx_q <= 1'b0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
            rdata_q    <= '0;
        end else begin
            if (ram_wea) wr_last_q <= wg1;
            if (rd_any) rd_last_q <= rg1;
            rtag_v_q   <= rd_any;
            rtag_idx_q <= rg1;
            fwd_q      <= collide;
            if (collide) fwd_data_q <= ram_dina;
            rdata_q    <= rdata_d;
        end
    end
endmodule

// File: tb/tb_dpram_access_arbiter.sv
// tb_dpram_access_arbiter: directed checks of the arbiter against a
// behavioural read-first dual-port RAM.
module tb_dpram_access_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_wea;
    logic [15:0] ram_addra, ram_addrb;
    logic [31:0] ram_dina, ram_doutb;
    logic [31:0] mem [0:65535];
    int          n_chk = 0;
    int          n_fail = 0;

    dpram_access_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
    );

    always #5 clk = ~clk;

    // read-first RAM: a same-cycle write is not visible to the read
    always @(posedge clk) begin
        if (ram_wea) mem[ram_addra] <= ram_dina;
        ram_doutb <= mem[ram_addrb];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        mem[3] = 32'h0000_0033;
        mem[4] = 32'h0000_0044;
        ram_doutb = '0;
        rst = 1'b1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0010; m0_wdata = 32'h1;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0010; m1_wdata = 32'h2;
        #2;
        chk("rst_m0_gnt", {31'b0, m0_gnt}, 32'd0);
        chk("rst_m1_gnt", {31'b0, m1_gnt}, 32'd0);
        chk("rst_wea", {31'b0, ram_wea}, 32'd0);
        chk("rst_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
        chk("rst_rdata", m0_rdata, 32'd0);
        tick(); tick();
        rst = 1'b0;
        m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0010; m0_wdata = 32'hDEADBEEF;
        #1;
        chk("wr_m0_gnt", {31'b0, m0_gnt}, 32'd1);
        chk("wr_wea", {31'b0, ram_wea}, 32'd1);
        chk("wr_addra", {16'b0, ram_addra}, 32'h0010);
        chk("wr_dina", ram_dina, 32'hDEADBEEF);
        tick();
        m0_req = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0010;
        #1;
        chk("rd_m1_gnt", {31'b0, m1_gnt}, 32'd1);
        chk("rd_addrb", {16'b0, ram_addrb}, 32'h0010);
        tick();
        m1_req = 1'b0;
        chk("rd_m1_rvalid", {31'b0, m1_rvalid}, 32'd1);
        chk("rd_m1_rdata", m1_rdata, 32'hDEADBEEF);
        chk("rd_m0_rvalid", {31'b0, m0_rvalid}, 32'd0);

        // continuous write contention right after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0001; m0_wdata = 32'hA;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0002; m1_wdata = 32'hB;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_wr_m0_gnt", {31'b0, m0_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_wr_m1_gnt", {31'b0, m1_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        chk("mem_1", mem[1], 32'hA);
        chk("mem_2", mem[2], 32'hB);

        // same-cycle write/read collision is forwarded
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0020; m0_wdata = 32'h12345678;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0020;
        #1;
        chk("col_m0_gnt", {31'b0, m0_gnt}, 32'd1);
        chk("col_m1_gnt", {31'b0, m1_gnt}, 32'd1);
        tick();
        chk("col_m1_rvalid", {31'b0, m1_rvalid}, 32'd1);
        chk("col_m1_rdata", m1_rdata, 32'h12345678);
        m0_req = 1'b0;
        m1_addr = 16'h0030;
        #1;
        chk("rd30_m1_gnt", {31'b0, m1_gnt}, 32'd1);
        tick();
        m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0030; m0_wdata = 32'h55;
        #1;
        chk("late_wr_gnt", {31'b0, m0_gnt}, 32'd1);
        chk("late_wr_rvalid", {31'b0, m1_rvalid}, 32'd1);
        chk("late_wr_rdata", m1_rdata, 32'd0);
        tick();
        m0_req = 1'b0;

        // back-to-back read contention
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0003;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0004;
        #1;
        chk("rr_rd_m0_gnt", {31'b0, m0_gnt}, 32'd1);
        chk("rr_rd_m1_gnt0", {31'b0, m1_gnt}, 32'd0);
        tick();
        chk("rr_rd_m1_gnt", {31'b0, m1_gnt}, 32'd1);
        chk("rr_rd_m0_gnt1", {31'b0, m0_gnt}, 32'd0);
        chk("rr_rd_m0_rvalid", {31'b0, m0_rvalid}, 32'd1);
        chk("rr_rd_m0_rdata", m0_rdata, 32'h33);
        tick();
        m0_req = 1'b0; m1_req = 1'b0;
        chk("rr_rd_m1_rvalid", {31'b0, m1_rvalid}, 32'd1);
        chk("rr_rd_m0_rvalid2", {31'b0, m0_rvalid}, 32'd0);
        chk("rr_rd_m1_rdata", m1_rdata, 32'h44);
        tick();
        chk("idle_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
        chk("idle_rdata_hold", m1_rdata, 32'h44);

        // reset drops an in-flight read and restores master-0 priority
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0003;
        #1;
        chk("inflight_gnt", {31'b0, m0_gnt}, 32'd1);
        @(posedge clk);
        rst = 1'b1;
        m0_req = 1'b0;
        #1;
        chk("inflight_rvalid", {31'b0, m0_rvalid}, 32'd0);
        chk("inflight_rdata", m0_rdata, 32'd0);
        tick();
        chk("inflight_rvalid2", {31'b0, m0_rvalid}, 32'd0);
        rst = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0005; m0_wdata = 32'h5;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0006; m1_wdata = 32'h6;
        #1;
        chk("post_rst_m0_gnt", {31'b0, m0_gnt}, 32'd1);
        chk("post_rst_m1_gnt", {31'b0, m1_gnt}, 32'd0);
        tick();
        chk("post_rst_m1_gnt2", {31'b0, m1_gnt}, 32'd1);
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
